// File: rtl/systolic_result_deskew.sv
`default_nettype none
// ============================================================================
// Module      : systolic_result_deskew
// Description : Re-aligns the diagonally skewed partial-sum wavefront leaving
//               the systolic array into whole rows and queues them in a small
//               FIFO towards the accumulator (valid/ready, drop on overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_result_deskew #(
    parameter int LANES      = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          valid_i,
    input  logic [DATA_W-1:0]             data_i [LANES],
    input  logic                          ready_i,
    output logic                          valid_o,
    output logic [DATA_W-1:0]             data_o [LANES],
    output logic [15:0]                   row_count_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int c_CHAIN_LEN = LANES - 1;
    localparam int c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W     = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Valid delay chain; its last stage is the FIFO write strobe
    // ------------------------------------------------------------------
    logic [c_CHAIN_LEN-1:0] r_vchain;
    logic                   w_wr_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vchain <= '0;
        end else if (clear_i) begin
            r_vchain <= '0;
        end else begin
            r_vchain <= (r_vchain << 1) | c_CHAIN_LEN'(valid_i);
        end
    end

    assign w_wr_valid = r_vchain[c_CHAIN_LEN-1];

    // ------------------------------------------------------------------
    // Per-lane deskew: lane k waits LANES-1-k cycles for the last column
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_row [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int c_DEPTH = LANES - 1 - k;
        if (c_DEPTH == 0) begin : g_direct
            assign w_row[k] = data_i[k];
        end else begin : g_delay
            logic [DATA_W-1:0] r_pipe [c_DEPTH];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < c_DEPTH; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= data_i[k];
                    for (int i = 1; i < c_DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_row[k] = r_pipe[c_DEPTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Aligned-row FIFO with registered head
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH][LANES];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_valid;
    logic [DATA_W-1:0]  r_data [LANES];
    logic [15:0]        r_row_count;
    logic               r_overflow;

    logic               w_pop;
    logic               w_full;
    logic               w_wr_en;
    logic               w_drop;
    logic [c_PTR_W-1:0] w_rd_next;
    logic [c_LVL_W-1:0] w_level_next;
    logic               w_head_bypass;
    logic [DATA_W-1:0]  w_head [LANES];

    assign w_pop        = r_valid & ready_i;
    assign w_full       = (r_level == c_FULL);
    assign w_wr_en      = w_wr_valid & (~w_full | w_pop);
    assign w_drop       = w_wr_valid & w_full & ~w_pop;
    assign w_rd_next    = r_rd_ptr + c_PTR_W'(w_pop);
    assign w_level_next = r_level + c_LVL_W'(w_wr_en) - c_LVL_W'(w_pop);

    // The next head is the row being written only when it lands in the
    // slot the read pointer moves to (FIFO empty after this cycle's pop).
    assign w_head_bypass = w_wr_en && (r_wr_ptr == w_rd_next);

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_head[k] = w_head_bypass ? w_row[k] : r_mem[w_rd_next][k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en && !clear_i) begin
            for (int k = 0; k < LANES; k++) begin
                r_mem[r_wr_ptr][k] <= w_row[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_valid     <= 1'b0;
            r_row_count <= '0;
            r_overflow  <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_data[k] <= '0;
            end
        end else if (clear_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_valid     <= 1'b0;
            r_row_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
            r_valid  <= (w_level_next != '0);
            // data_o keeps its last value while the FIFO is empty
            if (w_level_next != '0) begin
                for (int k = 0; k < LANES; k++) begin
                    r_data[k] <= w_head[k];
                end
            end
            if (w_pop) begin
                r_row_count <= r_row_count + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign valid_o      = r_valid;
    assign data_o       = r_data;
    assign row_count_o  = r_row_count;
    assign overflow_o   = r_overflow;
    assign fifo_level_o = r_level;

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_deskew.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_systolic_result_deskew
// Description : Directed, self-checking bench for systolic_result_deskew.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_result_deskew;

    localparam int LANES      = 32;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int MAXC       = 4096;

    logic              clk_i   = 1'b0;
    logic              rst_ni  = 1'b1;
    logic              clear_i = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_i = 1'b1;
    logic [DATA_W-1:0] data_i [LANES];
    logic              valid_o;
    logic [DATA_W-1:0] data_o [LANES];
    logic [15:0]       row_count_o;
    logic              overflow_o;
    logic [LVL_W-1:0]  fifo_level_o;

    systolic_result_deskew #(
        .LANES      (LANES),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .row_count_o  (row_count_o),
        .overflow_o   (overflow_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    int issue_at [MAXC];
    int errors = 0;
    int checks = 0;
    int exp_q [$];
    int first_v, last_v, vcnt, max_lvl;

    typedef struct {
        logic rdy;
        logic v;
        int   lvl;
        int   head;
    } vec_t;
    vec_t tbl [10];

    // Row id 0 is the single-row pattern 0x100+k; negative ids mean all-zero.
    function automatic logic [DATA_W-1:0] pat(int id, int k);
        if (id < 0) return '0;
        if (id == 0) return DATA_W'(32'h100 + k);
        return DATA_W'(id * 32'h1000 + k);
    endfunction

    task automatic drive_inputs();
        valid_i = (cyc < MAXC) && (issue_at[cyc] >= 0);
        for (int k = 0; k < LANES; k++) begin
            int c;
            c = cyc - k;
            if (c >= 0 && c < MAXC && issue_at[c] >= 0) data_i[k] = pat(issue_at[c], k);
            else data_i[k] = DATA_W'(32'hDEAD);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_row(string name, int id);
        int bad;
        bad = -1;
        checks++;
        for (int k = 0; k < LANES; k++) begin
            if (bad < 0 && data_o[k] !== pat(id, k)) bad = k;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: lane %0d got %h expected %h (cycle %0d)",
                     name, bad, data_o[bad], pat(id, bad), cyc);
        end
    endtask

    task automatic reset_stats();
        first_v = -1; last_v = -1; vcnt = 0; max_lvl = 0;
    endtask

    // Checks every pop against the expected-row queue, then advances.
    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            if (valid_o) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                vcnt++;
            end
            if (int'(fifo_level_o) > max_lvl) max_lvl = int'(fifo_level_o);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got valid row expected none (cycle %0d)", cyc);
                end else begin
                    check_row("pop_data", exp_q.pop_front());
                end
            end
            step();
        end
    endtask

    task automatic single_row(string tag);
        int t;
        reset_stats();
        ready_i = 1'b1;
        t = cyc + 1;
        issue_at[t] = 0;
        run(t + 32 - cyc);
        check({tag, "_no_early_valid"}, 64'(first_v), 64'(-1));
        check({tag, "_valid_at_t32"}, 64'(valid_o), 64'd1);
        check({tag, "_level"}, 64'(fifo_level_o), 64'd1);
        check_row({tag, "_row_data"}, 0);
        step();
        check({tag, "_valid_one_cycle"}, 64'(valid_o), 64'd0);
        check({tag, "_row_count"}, 64'(row_count_o), 64'd1);
    endtask

    initial begin
        int s, u;
        for (int i = 0; i < MAXC; i++) issue_at[i] = -1;
        tbl[0] = '{1'b0, 1'b0, 0, -1};
        tbl[1] = '{1'b0, 1'b1, 1, 11};
        tbl[2] = '{1'b0, 1'b1, 2, 11};
        tbl[3] = '{1'b0, 1'b1, 3, 11};
        tbl[4] = '{1'b0, 1'b1, 4, 11};
        tbl[5] = '{1'b1, 1'b1, 4, 11};
        tbl[6] = '{1'b1, 1'b1, 3, 12};
        tbl[7] = '{1'b1, 1'b1, 2, 13};
        tbl[8] = '{1'b1, 1'b1, 1, 14};
        tbl[9] = '{1'b1, 1'b0, 0, -1};
        drive_inputs();

        // Reset state
        #1 rst_ni = 1'b0;
        step();
        step();
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_level", 64'(fifo_level_o), 64'd0);
        check("rst_count", 64'(row_count_o), 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        check_row("rst_data", -1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single row
        single_row("t1");

        // Streaming
        reset_stats();
        s = cyc + 1;
        for (int r = 0; r < 8; r++) begin
            issue_at[s + r] = r + 1;
            exp_q.push_back(r + 1);
        end
        run(45);
        check("t2_first_valid", 64'(first_v), 64'(s + 32));
        check("t2_last_valid", 64'(last_v), 64'(s + 39));
        check("t2_valid_count", 64'(vcnt), 64'd8);
        check("t2_max_level", 64'(max_lvl), 64'd1);
        check("t2_overflow", 64'(overflow_o), 64'd0);
        check("t2_row_count", 64'(row_count_o), 64'd9);
        check("t2_all_popped", 64'(exp_q.size()), 64'd0);

        // Backpressure: table-driven from the cycle of the first write
        ready_i = 1'b0;
        s = cyc + 1;
        for (int r = 0; r < 4; r++) issue_at[s + r] = 11 + r;
        while (cyc < s + 31) step();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_valid[%0d]", i), 64'(valid_o), 64'(tbl[i].v));
            check($sformatf("t3_level[%0d]", i), 64'(fifo_level_o), 64'(tbl[i].lvl));
            if (tbl[i].head >= 0) check_row($sformatf("t3_head[%0d]", i), tbl[i].head);
            ready_i = tbl[i].rdy;
            step();
        end
        check("t3_overflow", 64'(overflow_o), 64'd0);
        check("t3_row_count", 64'(row_count_o), 64'd13);

        // Overflow: fifth row dropped
        ready_i = 1'b0;
        s = cyc + 1;
        for (int r = 0; r < 5; r++) issue_at[s + r] = 21 + r;
        while (cyc < s + 35) step();
        check("t4_ovf_before", 64'(overflow_o), 64'd0);
        check("t4_level_full", 64'(fifo_level_o), 64'd4);
        step();
        check("t4_ovf_set", 64'(overflow_o), 64'd1);
        check("t4_level_kept", 64'(fifo_level_o), 64'd4);
        check_row("t4_head_row0", 21);
        repeat (3) step();
        check("t4_ovf_sticky", 64'(overflow_o), 64'd1);
        ready_i = 1'b1;
        reset_stats();
        for (int r = 0; r < 4; r++) exp_q.push_back(21 + r);
        run(8);
        check("t4_drained", 64'(exp_q.size()), 64'd0);
        check("t4_level_empty", 64'(fifo_level_o), 64'd0);
        check("t4_ovf_after_drain", 64'(overflow_o), 64'd1);
        check("t4_row_count", 64'(row_count_o), 64'd17);

        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("t4_clear_ovf", 64'(overflow_o), 64'd0);
        check("t4_clear_count", 64'(row_count_o), 64'd0);

        // Full FIFO with pop in the write cycle: no overflow
        ready_i = 1'b0;
        s = cyc + 1;
        for (int r = 0; r < 5; r++) issue_at[s + r] = 31 + r;
        while (cyc < s + 35) step();
        check("t4v_level_full", 64'(fifo_level_o), 64'd4);
        check_row("t4v_head", 31);
        ready_i = 1'b1;
        step();
        check("t4v_no_ovf", 64'(overflow_o), 64'd0);
        check("t4v_level_same", 64'(fifo_level_o), 64'd4);
        for (int r = 0; r < 4; r++) exp_q.push_back(32 + r);
        run(6);
        check("t4v_drained", 64'(exp_q.size()), 64'd0);
        check("t4v_row_count", 64'(row_count_o), 64'd5);

        // clear_i mid-flight with two queued rows
        ready_i = 1'b0;
        s = cyc + 1;
        issue_at[s] = 41;
        issue_at[s + 1] = 42;
        while (cyc < s + 33) step();
        check("t5_queued", 64'(fifo_level_o), 64'd2);
        u = cyc + 1;
        issue_at[u] = 43;
        issue_at[u + 15] = 44;
        while (cyc < u + 15) step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("t5_valid", 64'(valid_o), 64'd0);
        check("t5_level", 64'(fifo_level_o), 64'd0);
        check("t5_count", 64'(row_count_o), 64'd0);
        check("t5_ovf", 64'(overflow_o), 64'd0);
        ready_i = 1'b1;
        reset_stats();
        run(40);
        check("t5_no_ghost_rows", 64'(vcnt), 64'd0);

        // Asynchronous reset while valid_o is high
        ready_i = 1'b1;
        s = cyc + 1;
        issue_at[s] = 50;
        issue_at[s + 1] = 51;
        exp_q.push_back(50);
        while (cyc < s + 33) run(1);
        check("t6_valid_pre", 64'(valid_o), 64'd1);
        check("t6_count_pre", 64'(row_count_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_valid_async", 64'(valid_o), 64'd0);
        check("t6_level_async", 64'(fifo_level_o), 64'd0);
        check("t6_count_async", 64'(row_count_o), 64'd0);
        check("t6_ovf_async", 64'(overflow_o), 64'd0);
        check_row("t6_data_async", -1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_q.delete();
        single_row("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/systolic_result_deskew.md
Name: systolic_result_deskew

Overview:
- Downstream neighbour of the activation skew stage: consumes the diagonally skewed partial-sum wavefront leaving the bottom of the systolic array and re-aligns it into whole result rows.
- Column k of a row exits the array k cycles after column 0. The block delays each lane so all columns land together.
- Aligned rows are buffered in a small FIFO and handed to the accumulator stage with a valid/ready handshake.
- The array cannot stall, so a FIFO overflow drops the row and raises a sticky flag.

Parameters:
- LANES, 32, number of array columns / lanes
- DATA_W, 32, partial-sum width per lane
- FIFO_DEPTH, 4, aligned-row FIFO entries (power of 2, >=2)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush of pipeline, FIFO, count and flag
- valid_i  in  1  high in the cycle lane 0 of a new row is present; lane k of that row arrives k cycles later
- data_i  in  DATA_W x LANES  unpacked array of skewed column outputs from the array
- ready_i  in  1  accumulator accepts data_o this cycle
- valid_o  out  1  data_o holds an aligned row
- data_o  out  DATA_W x LANES  aligned row, index = column
- row_count_o  out  16  rows popped since reset/clear, wraps at 2^16
- overflow_o  out  1  sticky: an aligned row was dropped on a full FIFO
- fifo_level_o  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_ni low, asynchronous): the following all go to 0 immediately:
  - lane delay registers, valid delay chain, FIFO pointers and level
  - valid_o, data_o, row_count_o, overflow_o
- Deskew delay lines:
  - Lane k passes through LANES-1-k registers. Lane LANES-1 is unregistered.
  - valid_i passes through a LANES-1 stage shift chain (wr_valid).
  - Delay registers shift every cycle unconditionally. There is no stall path.
- FIFO write (write strobe = wr_valid):
  - Aligned row = {lane0 delayed 31, ..., lane31 direct}.
  - The row is written in the cycle wr_valid is high.
  - Row valid_i at cycle t is written at the edge ending cycle t+LANES-1.
- Output:
  - FIFO head is registered; data_o/valid_o reflect the head.
  - Latency into an empty FIFO: valid_i at cycle t -> valid_o high at cycle t+LANES (32).
- Handshake:
  - Pop when valid_o && ready_i; the next head appears the following cycle.
  - data_o is stable while valid_o && !ready_i.
  - When valid_o is low, data_o holds its last value and is don't-care.
- Back-to-back rows: valid_i may assert every cycle; one row per cycle is written.
- Full/overflow:
  - Write while level == FIFO_DEPTH and no pop in the same cycle: row discarded, overflow_o set, FIFO contents untouched.
  - Write and pop in the same cycle while full: both occur, level unchanged, no overflow.
- Empty: a pop is impossible (valid_o low). Write into an empty FIFO sets valid_o next cycle.
- row_count_o: increments on each pop; 0xFFFF wraps to 0.
- clear_i (synchronous, highest priority):
  - Next cycle: valid chain zeroed (in-flight partial rows abandoned), FIFO emptied, valid_o=0, row_count_o=0, overflow_o=0.
  - Lane data registers need not clear.
  - A valid_i coincident with clear_i is dropped.
- Reset mid-row: all in-flight rows are lost; no partial row is ever emitted.
- Width: data passes unmodified (no arithmetic). fifo_level_o counts 0..FIFO_DEPTH.

Test Plan:
1. Single row, ready_i=1:
   - Stimulus: valid_i at cycle 10; lane k = 0x100+k driven at cycle 10+k, other cycles 0xDEAD.
   - Required: valid_o exactly at cycle 42 for one cycle; data_o[k]=0x100+k for all k; row_count_o=1 at cycle 43.
2. Streaming, ready_i=1:
   - Stimulus: 8 consecutive rows (row r lane k = r*0x1000+k).
   - Required: 8 consecutive valid_o cycles in order, correct values, fifo_level_o never >1, overflow_o=0, row_count_o=8.
3. Backpressure:
   - Stimulus: ready_i=0; 4 rows back-to-back.
   - Required: fifo_level_o reaches 4; data_o holds row0 stable; overflow_o=0.
   - Then: ready_i=1 drains rows 0..3 in order over 4 cycles.
4. Overflow:
   - Stimulus: ready_i=0; 5 rows.
   - Required: row4 dropped; overflow_o=1 from the cycle after its write attempt and stays high; drained contents are rows 0..3.
   - Variant: full FIFO with ready_i=1 in the write cycle -> no overflow.
5. clear_i mid-flight:
   - Stimulus: row issued at cycle 0, clear_i at cycle 15, 2 rows already queued.
   - Required: valid_o=0 from cycle 16; the in-flight row never appears; row_count_o=0, overflow_o=0, fifo_level_o=0.
6. Async reset:
   - Stimulus: rst_ni pulsed low mid-cycle while valid_o=1.
   - Required: all outputs 0 immediately, without waiting for a clock edge; after release, a fresh row behaves as in test 1.
